reg_file8x16: RTL and testbench

Eight-entry, 16-bit general register file for the hardwired MIPS16-like datapath. It sits directly upstream of the 8-way one-hot operand selector and feeds it:
- all eight register values go out in parallel;
- two one-hot read-select vectors are decoded from the instruction's 3-bit register fields.

A per-register busy scoreboard tracks multi-cycle producers (memory loads) and raises a stall when a selected operand is not yet valid.

---
 rtl/regfile_pkg.sv | 11 +
 rtl/dec3_8_onehot.sv | 16 +
 rtl/reg_file8x16.sv | 97 +++++++++
 tb/tb_reg_file8x16.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the 8x16 register file and its select decoders.
package regfile_pkg;

  localparam int REG_W   = 16;
  localparam int REG_N   = 8;
  localparam int RADDR_W = 3;

  typedef logic [REG_W-1:0] word_t;
  typedef logic [REG_N-1:0] sel_t;

endpackage : regfile_pkg

// File: rtl/dec3_8_onehot.sv
// 3-bit index to 8-bit one-hot decoder with enable; all-zero when disabled.
module dec3_8_onehot
  import regfile_pkg::*;
(
  input  logic               en,
  input  logic [RADDR_W-1:0] idx,
  output sel_t               onehot
);

  // Exactly one bit set when enabled, never multi-hot.
  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule : dec3_8_onehot

// File: rtl/reg_file8x16.sv
// Eight-entry 16-bit register file with busy scoreboard and one-hot
// read-select outputs for the downstream operand selector.
// Optional build macro: REGFILE_BYPASS_EN (write-through to rN outputs and
// stall suppression for a register completing this cycle).
module reg_file8x16
  import regfile_pkg::*;
#(
  parameter int REG_W = regfile_pkg::REG_W,
  parameter int REG_N = regfile_pkg::REG_N
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [RADDR_W-1:0] waddr,
  input  logic [REG_W-1:0]   wdata,
  input  logic               wb_clr,
  input  logic               iss,
  input  logic [RADDR_W-1:0] iss_addr,
  input  logic               ra_en,
  input  logic [RADDR_W-1:0] ra_addr,
  input  logic               rb_en,
  input  logic [RADDR_W-1:0] rb_addr,
  output logic [REG_W-1:0]   r0,
  output logic [REG_W-1:0]   r1,
  output logic [REG_W-1:0]   r2,
  output logic [REG_W-1:0]   r3,
  output logic [REG_W-1:0]   r4,
  output logic [REG_W-1:0]   r5,
  output logic [REG_W-1:0]   r6,
  output logic [REG_W-1:0]   r7,
  output logic [REG_N-1:0]   ya,
  output logic [REG_N-1:0]   yb,
  output logic [REG_N-1:0]   busy,
  output logic               stall
);

  logic [REG_W-1:0] regs [REG_N];
  logic [REG_W-1:0] rd   [REG_N];
  logic [REG_N-1:0] wsel;
  logic [REG_N-1:0] busy_nxt;
  logic [REG_N-1:0] busy_eff;

  dec3_8_onehot u_dec_a (.en(ra_en), .idx(ra_addr), .onehot(ya));
  dec3_8_onehot u_dec_b (.en(rb_en), .idx(rb_addr), .onehot(yb));
  dec3_8_onehot u_dec_w (.en(we),    .idx(waddr),   .onehot(wsel));

  // Scoreboard update: completion clears first, so a same-edge issue to the
  // same register leaves it busy (the new producer wins).
  always_comb begin
    busy_nxt = busy;
    if (we && wb_clr) busy_nxt[waddr] = 1'b0;
    if (iss)          busy_nxt[iss_addr] = 1'b1;
  end

  // Register array and scoreboard state; reset overrides any write or issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_N; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      for (int i = 0; i < REG_N; i++) begin
        if (wsel[i]) regs[i] <= wdata;
      end
      busy <= busy_nxt;
    end
  end

  // Register outputs, optionally forwarding the in-flight write.
  always_comb begin
    rd = regs;
`ifdef REGFILE_BYPASS_EN
    for (int i = 0; i < REG_N; i++) begin
      if (wsel[i]) rd[i] = wdata;
    end
`endif
  end

  // Busy view used for stall; a completing write counts as valid when forwarded.
  always_comb begin
    busy_eff = busy;
`ifdef REGFILE_BYPASS_EN
    if (we && wb_clr) busy_eff[waddr] = 1'b0;
`endif
  end

  assign stall = (ra_en & busy_eff[ra_addr]) | (rb_en & busy_eff[rb_addr]);

  assign r0 = rd[0];
  assign r1 = rd[1];
  assign r2 = rd[2];
  assign r3 = rd[3];
  assign r4 = rd[4];
  assign r5 = rd[5];
  assign r6 = rd[6];
  assign r7 = rd[7];

endmodule : reg_file8x16

// File: tb/tb_reg_file8x16.sv
// Directed self-checking bench for reg_file8x16.
module tb_reg_file8x16;

  logic        clk = 1'b0;
  logic        rst, we, wb_clr, iss, ra_en, rb_en;
  logic [2:0]  waddr, iss_addr, ra_addr, rb_addr;
  logic [15:0] wdata;
  logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;
  logic [7:0]  ya, yb, busy;
  logic        stall;
  logic [15:0] r_arr [8];

  int checks   = 0;
  int failures = 0;

  reg_file8x16 dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .wb_clr(wb_clr), .iss(iss), .iss_addr(iss_addr),
    .ra_en(ra_en), .ra_addr(ra_addr), .rb_en(rb_en), .rb_addr(rb_addr),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
    .ya(ya), .yb(yb), .busy(busy), .stall(stall)
  );

  always #5 clk = ~clk;

  assign r_arr[0] = r0;
  assign r_arr[1] = r1;
  assign r_arr[2] = r2;
  assign r_arr[3] = r3;
  assign r_arr[4] = r4;
  assign r_arr[5] = r5;
  assign r_arr[6] = r6;
  assign r_arr[7] = r7;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Models the downstream one-hot operand selector.
  function automatic logic [15:0] sel_mux(input logic [7:0] y);
    logic [15:0] acc = '0;
    for (int i = 0; i < 8; i++) if (y[i]) acc |= r_arr[i];
    return acc;
  endfunction

  initial begin
    rst = 1'b1; we = 0; wb_clr = 0; iss = 0; ra_en = 0; rb_en = 0;
    waddr = 0; iss_addr = 0; ra_addr = 0; rb_addr = 0; wdata = 16'h0000;
    step();
    step();
    rst = 1'b0;
    step();

    for (int i = 0; i < 8; i++) check($sformatf("reset_r%0d", i), {16'h0, r_arr[i]}, 32'h0);
    check("reset_busy",  {24'h0, busy}, 32'h00);
    check("reset_ya",    {24'h0, ya},   32'h00);
    check("reset_yb",    {24'h0, yb},   32'h00);
    check("reset_stall", {31'h0, stall}, 32'h0);

    // Write r5 and select it on port A
    we = 1; waddr = 3'd5; wdata = 16'h1234; ra_en = 1; ra_addr = 3'd5;
    #1;
    check("ya_r5_comb", {24'h0, ya}, 32'h20);
    step();
    we = 0;
    #1;
    check("r5_written", {16'h0, r5}, 32'h1234);
    check("sel_a_r5",   {16'h0, sel_mux(ya)}, 32'h1234);
    rb_en = 1; rb_addr = 3'd0;
    #1;
    check("yb_r0", {24'h0, yb}, 32'h01);
    rb_addr = 3'd7;
    #1;
    check("yb_r7", {24'h0, yb}, 32'h80);
    rb_en = 0;
    #1;
    check("yb_dis", {24'h0, yb}, 32'h00);

    // Issue a load to r3 and read it
    iss = 1; iss_addr = 3'd3; ra_addr = 3'd3;
    #1;
    check("stall_pre_iss", {31'h0, stall}, 32'h0);
    step();
    iss = 0;
    #1;
    check("busy_r3_set", {24'h0, busy}, 32'h08);
    check("stall_a_r3",  {31'h0, stall}, 32'h1);
    ra_en = 0; rb_en = 1; rb_addr = 3'd3;
    #1;
    check("stall_b_r3", {31'h0, stall}, 32'h1);
    rb_en = 0;
    #1;
    check("stall_none_en", {31'h0, stall}, 32'h0);
    ra_en = 1;
    we = 1; wb_clr = 1; waddr = 3'd3; wdata = 16'hBEEF;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("stall_bypass_clr", {31'h0, stall}, 32'h0);
    check("r3_bypass",        {16'h0, r3}, 32'hBEEF);
`else
    check("stall_nobypass_clr", {31'h0, stall}, 32'h1);
    check("r3_old",             {16'h0, r3}, 32'h0000);
`endif
    step();
    we = 0; wb_clr = 0;
    #1;
    check("stall_r3_done", {31'h0, stall}, 32'h0);
    check("busy_r3_clr",   {24'h0, busy}, 32'h00);
    check("r3_beef",       {16'h0, r3}, 32'hBEEF);

    // wb_clr without we has no effect
    iss = 1; iss_addr = 3'd1;
    step();
    iss = 0; wb_clr = 1; waddr = 3'd1;
    step();
    wb_clr = 0;
    #1;
    check("wbclr_no_we", {24'h0, busy}, 32'h02);
    check("r1_untouched", {16'h0, r1}, 32'h0000);
    we = 1; wb_clr = 1; waddr = 3'd1; wdata = 16'h0001;
    step();
    we = 0; wb_clr = 0;
    #1;
    check("busy_r1_clr", {24'h0, busy}, 32'h00);

    // Same-edge issue and completion to r2: new producer wins
    iss = 1; iss_addr = 3'd2; we = 1; wb_clr = 1; waddr = 3'd2; wdata = 16'hA5A5;
    step();
    iss = 0; we = 0; wb_clr = 0;
    #1;
    check("busy_r2_kept", {24'h0, busy}, 32'h04);
    check("r2_written",   {16'h0, r2}, 32'hA5A5);

    // Issue r3 again so busy = 0C
    iss = 1; iss_addr = 3'd3;
    step();
    iss = 0;
    #1;
    check("busy_0c", {24'h0, busy}, 32'h0C);

    // Read-during-write of r7
    ra_addr = 3'd7; we = 1; waddr = 3'd7; wdata = 16'hFFFF;
    #1;
    check("sel_a_r7_pre", {24'h0, ya}, 32'h80);
`ifdef REGFILE_BYPASS_EN
    check("r7_same_cycle", {16'h0, r7}, 32'hFFFF);
`else
    check("r7_same_cycle", {16'h0, r7}, 32'h0000);
`endif
    step();
    we = 0;
    #1;
    check("r7_next", {16'h0, r7}, 32'hFFFF);
    check("sel_a_r7", {16'h0, sel_mux(ya)}, 32'hFFFF);

    // Reset with busy loads, concurrent write and issue ignored
    rst = 1; we = 1; waddr = 3'd0; wdata = 16'h5555; iss = 1; iss_addr = 3'd0;
    step();
    rst = 0; we = 0; iss = 0;
    #1;
    check("rst_busy", {24'h0, busy}, 32'h00);
    for (int i = 0; i < 8; i++) check($sformatf("rst_r%0d", i), {16'h0, r_arr[i]}, 32'h0);

    // Late completion after reset is a normal write
    we = 1; wb_clr = 1; waddr = 3'd2; wdata = 16'h1111;
    step();
    we = 0; wb_clr = 0;
    #1;
    check("late_wb_r2",   {16'h0, r2}, 32'h1111);
    check("late_wb_busy", {24'h0, busy}, 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_reg_file8x16
